// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and default widths for the PWM driver and its line feeder
package pwm_pkg;

    localparam int PWM_DWIDTH = 8;
    localparam int PWM_STAGE  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with registered occupancy and full/empty flags
module byte_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DWIDTH-1:0]        push_data,
    input  logic                     pop,
    output logic [DWIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pwm_line_feeder.sv
// rtl/pwm_line_feeder.sv - buffers producer bytes and replays them as paced STAGE-byte line bursts
module pwm_line_feeder
    import pwm_pkg::*;
#(
    parameter int DWIDTH      = PWM_DWIDTH,
    parameter int STAGE       = PWM_STAGE,
    parameter int FIFO_DEPTH  = 16,
    parameter int LINE_PERIOD = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DWIDTH-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          enable,
    output logic                          start,
    output logic [DWIDTH-1:0]             data,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(LINE_PERIOD);
    localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1;

    localparam logic [FW-1:0] STAGE_FILL  = FW'(STAGE);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(LINE_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(STAGE - 1);

    feeder_state_t     state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              start_q, start_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;

    logic              fifo_push, fifo_pop, pop_req, launch, can_start;
    logic [DWIDTH-1:0] fifo_head;
    logic [FW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;

    byte_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign fifo_pop  = pop_req && !fifo_empty;
    assign can_start = enable && (fifo_count >= STAGE_FILL);

    assign start    = start_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;
    assign fill     = fifo_count;

    // A burst is only launched with a full line already buffered, so the
    // pops that follow can never run the FIFO dry mid-burst.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        data_d     = '0;
        underrun_d = 1'b0;
        pop_req    = 1'b0;
        launch     = 1'b0;
        case (state_q)
            IDLE: begin
                launch = can_start;
            end
            LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = HOLD;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    data_d  = fifo_head;
                    pop_req = 1'b1;
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PERIOD_LAST) begin
                    if (can_start) begin
                        launch = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        underrun_d = enable;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (launch) begin
            state_d = LOAD;
            idx_d   = '0;
            cnt_d   = '0;
            start_d = 1'b1;
            data_d  = fifo_head;
            pop_req = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
